// File: rtl/shreg_pkg.sv
// Shared types for the universal shift register: operation codes and FSM states.
// Also holds a helper that identifies the modes that move bits.
package shreg_pkg;

    typedef enum logic [2:0] {
        MODE_HOLD = 3'd0,
        MODE_LOAD = 3'd1,
        MODE_SHL  = 3'd2,
        MODE_SHR  = 3'd3,
        MODE_SAR  = 3'd4,
        MODE_ROL  = 3'd5,
        MODE_ROR  = 3'd6,
        MODE_RSVD = 3'd7
    } shreg_mode_t;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    function automatic logic is_shift(input shreg_mode_t m);
        return (m == MODE_SHL) || (m == MODE_SHR) || (m == MODE_SAR) ||
               (m == MODE_ROL) || (m == MODE_ROR);
    endfunction

endpackage

// File: rtl/shreg_step.sv
// Combinational single-step shifter: computes the next register value and the
// bit that falls out for one shift of the given mode.
module shreg_step
    import shreg_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] q,
    input  shreg_mode_t      mode,
    input  logic             ser_in,
    output logic [WIDTH-1:0] q_next,
    output logic             shift_out
);

    // NOTE: every output gets a default first so no path through the case infers a latch.
    always_comb begin
        q_next    = q;
        shift_out = 1'b0;
        case (mode)
            MODE_SHL: begin
                q_next    = {q[WIDTH-2:0], ser_in};
                shift_out = q[WIDTH-1];
            end
            MODE_SHR: begin
                q_next    = {ser_in, q[WIDTH-1:1]};
                shift_out = q[0];
            end
            MODE_SAR: begin
                q_next    = {q[WIDTH-1], q[WIDTH-1:1]};
                shift_out = q[0];
            end
            MODE_ROL: begin
                q_next    = {q[WIDTH-2:0], q[WIDTH-1]};
                shift_out = q[WIDTH-1];
            end
            MODE_ROR: begin
                q_next    = {q[0], q[WIDTH-1:1]};
                shift_out = q[0];
            end
            default: begin
                q_next    = q;
                shift_out = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/univ_shift_reg.sv
// Universal shift register: parallel load plus logical/arithmetic/rotate shifts,
// executed one bit per clock under a start/busy/done handshake.
module univ_shift_reg
    import shreg_pkg::*;
#(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0,
    localparam int              CNT_W     = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       mode,
    input  logic [CNT_W-1:0] amount,
    input  logic [WIDTH-1:0] load_data,
    input  logic             ser_in,
    output logic [WIDTH-1:0] q,
    output logic             ser_out,
    output logic             busy,
    output logic             done
);

    localparam logic [CNT_W-1:0] WIDTH_C = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);

    state_t           state, state_next;
    logic [CNT_W-1:0] remaining, remaining_next;
    shreg_mode_t      mode_r;
    shreg_mode_t      mode_in;
    shreg_mode_t      step_mode;
    logic [CNT_W-1:0] amount_clamped;
    logic             accept;
    logic             do_load;
    logic             do_step;
    logic             done_next;
    logic [WIDTH-1:0] step_q;
    logic             step_out;

    assign mode_in        = shreg_mode_t'(mode);
    assign amount_clamped = (amount > WIDTH_C) ? WIDTH_C : amount;
    assign accept         = (state == IDLE) && start;
    // The first step is taken on the accepting edge, so the step unit sees the live mode in IDLE.
    assign step_mode      = (state == IDLE) ? mode_in : mode_r;

    shreg_step #(
        .WIDTH(WIDTH)
    ) u_step (
        .q        (q),
        .mode     (step_mode),
        .ser_in   (ser_in),
        .q_next   (step_q),
        .shift_out(step_out)
    );

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            remaining <= '0;
        end else begin
            state     <= state_next;
            remaining <= remaining_next;
        end
    end

    always_comb begin
        state_next     = state;
        remaining_next = remaining;
        case (state)
            IDLE: begin
                if (accept && is_shift(mode_in) && (amount_clamped > ONE_C)) begin
                    state_next     = SHIFT;
                    remaining_next = amount_clamped - ONE_C;
                end
            end
            SHIFT: begin
                remaining_next = remaining - ONE_C;
                if (remaining == ONE_C) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        do_load   = 1'b0;
        do_step   = 1'b0;
        done_next = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    do_load   = (mode_in == MODE_LOAD);
                    do_step   = is_shift(mode_in) && (amount_clamped != '0);
                    done_next = !(is_shift(mode_in) && (amount_clamped > ONE_C));
                end
            end
            SHIFT: begin
                do_step   = 1'b1;
                done_next = (remaining == ONE_C);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q       <= RESET_VAL;
            ser_out <= 1'b0;
            done    <= 1'b0;
            mode_r  <= MODE_HOLD;
        end else begin
            done <= done_next;
            if (accept) begin
                mode_r <= mode_in;
            end
            if (do_load) begin
                q <= load_data;
            end else if (do_step) begin
                q       <= step_q;
                ser_out <= step_out;
            end
        end
    end

    assign busy = (state == SHIFT);

endmodule

// File: tb/tb_univ_shift_reg.sv
// Directed testbench for univ_shift_reg (WIDTH=8, RESET_VAL=8'hA5) with
// hand-computed expectations checked by immediate assertions.
module tb_univ_shift_reg;
    import shreg_pkg::*;

    localparam int WIDTH = 8;
    localparam int CNT_W = $clog2(WIDTH + 1);

    logic             clk;
    logic             reset;
    logic             start;
    logic [2:0]       mode;
    logic [CNT_W-1:0] amount;
    logic [WIDTH-1:0] load_data;
    logic             ser_in;
    logic [WIDTH-1:0] q;
    logic             ser_out;
    logic             busy;
    logic             done;

    int total = 0;
    int bad   = 0;
    int busy_cnt;
    int done_cnt;

    univ_shift_reg #(
        .WIDTH    (WIDTH),
        .RESET_VAL(8'hA5)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .mode     (mode),
        .amount   (amount),
        .load_data(load_data),
        .ser_in   (ser_in),
        .q        (q),
        .ser_out  (ser_out),
        .busy     (busy),
        .done     (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge; outputs are sampled 1 time unit later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic cmd(input logic [2:0] m, input logic [CNT_W-1:0] amt, input logic [7:0] ld);
        start     = 1'b1;
        mode      = m;
        amount    = amt;
        load_data = ld;
    endtask

    initial begin
        reset = 1'b0; start = 1'b0; mode = 3'd0; amount = '0; load_data = '0; ser_in = 1'b0;

        // Asynchronous reset, between edges
        #1 reset = 1'b1;
        #1;
        check("rst_q", q, 8'hA5);
        check("rst_busy", 8'(busy), 8'h00);
        check("rst_done", 8'(done), 8'h00);
        check("rst_ser_out", 8'(ser_out), 8'h00);
        #6 reset = 1'b0;

        // LOAD 3C
        cmd(MODE_LOAD, 4'd0, 8'h3C);
        step();
        check("load_q", q, 8'h3C);
        check("load_done", 8'(done), 8'h01);
        check("load_busy", 8'(busy), 8'h00);
        start = 1'b0;
        step();
        check("load_done_clear", 8'(done), 8'h00);
        check("load_q_hold", q, 8'h3C);

        // SHL by 3 with ser_in=1
        ser_in = 1'b1;
        cmd(MODE_SHL, 4'd3, 8'h00);
        step();
        start = 1'b0;
        check("shl_q1", q, 8'h79);
        check("shl_busy1", 8'(busy), 8'h01);
        check("shl_done1", 8'(done), 8'h00);
        check("shl_out1", 8'(ser_out), 8'h00);
        step();
        check("shl_q2", q, 8'hF3);
        check("shl_busy2", 8'(busy), 8'h01);
        step();
        check("shl_q3", q, 8'hE7);
        check("shl_busy3", 8'(busy), 8'h00);
        check("shl_done3", 8'(done), 8'h01);
        check("shl_out3", 8'(ser_out), 8'h01);
        step();
        check("shl_done_clear", 8'(done), 8'h00);

        // LOAD 90, then SAR by 2 started in the same cycle as done
        ser_in = 1'b0;
        cmd(MODE_LOAD, 4'd0, 8'h90);
        step();
        check("ld90_q", q, 8'h90);
        check("ld90_done", 8'(done), 8'h01);
        cmd(MODE_SAR, 4'd2, 8'h00);
        step();
        start = 1'b0;
        check("sar_q1", q, 8'hC8);
        check("sar_busy1", 8'(busy), 8'h01);
        check("sar_done1", 8'(done), 8'h00);
        step();
        check("sar_q2", q, 8'hE4);
        check("sar_busy2", 8'(busy), 8'h00);
        check("sar_done2", 8'(done), 8'h01);

        // SHL by 0: no movement, immediate done
        cmd(MODE_SHL, 4'd0, 8'h00);
        step();
        start = 1'b0;
        check("shl0_q", q, 8'hE4);
        check("shl0_done", 8'(done), 8'h01);
        check("shl0_busy", 8'(busy), 8'h00);
        step();
        check("shl0_done_clear", 8'(done), 8'h00);

        // ROR by 12 (clamped to 8) with ignored re-starts while busy
        cmd(MODE_LOAD, 4'd0, 8'h81);
        step();
        cmd(MODE_ROR, 4'd12, 8'h00);
        step();
        check("ror_q1", q, 8'hC0);
        busy_cnt = busy ? 1 : 0;
        done_cnt = done ? 1 : 0;
        for (int i = 1; i <= 7; i++) begin
            if (i == 2 || i == 4) cmd(MODE_LOAD, 4'd1, 8'hFF);
            else start = 1'b0;
            step();
            busy_cnt += busy ? 1 : 0;
            done_cnt += done ? 1 : 0;
        end
        start = 1'b0;
        check("ror_q8", q, 8'h81);
        check("ror_busy_cycles", 8'(busy_cnt), 8'd7);
        check("ror_done_count", 8'(done_cnt), 8'd1);
        check("ror_done_end", 8'(done), 8'h01);
        check("ror_out", 8'(ser_out), 8'h01);
        step();
        check("ror_done_clear", 8'(done), 8'h00);

        // ROL by 1: single step, no busy
        cmd(MODE_ROL, 4'd1, 8'h00);
        step();
        start = 1'b0;
        check("rol_q", q, 8'h03);
        check("rol_busy", 8'(busy), 8'h00);
        check("rol_done", 8'(done), 8'h01);
        check("rol_out", 8'(ser_out), 8'h01);

        // Reserved code behaves as HOLD
        cmd(3'd7, 4'd3, 8'h55);
        step();
        start = 1'b0;
        check("rsvd_q", q, 8'h03);
        check("rsvd_done", 8'(done), 8'h01);
        check("rsvd_busy", 8'(busy), 8'h00);

        // SHR by 5 aborted by reset after the 2nd step
        ser_in = 1'b0;
        cmd(MODE_SHR, 4'd5, 8'h00);
        step();
        start = 1'b0;
        check("shr_q1", q, 8'h01);
        step();
        check("shr_q2", q, 8'h00);
        check("shr_busy2", 8'(busy), 8'h01);
        #2 reset = 1'b1;
        #1;
        check("abort_q", q, 8'hA5);
        check("abort_busy", 8'(busy), 8'h00);
        check("abort_done", 8'(done), 8'h00);
        check("abort_ser_out", 8'(ser_out), 8'h00);
        #1 reset = 1'b0;
        cmd(MODE_LOAD, 4'd0, 8'h00);
        step();
        start = 1'b0;
        check("post_rst_load_q", q, 8'h00);
        check("post_rst_load_done", 8'(done), 8'h01);
        check("post_rst_load_busy", 8'(busy), 8'h00);
        step();
        check("post_rst_done_clear", 8'(done), 8'h00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
